// File: rtl/conv_result_drain_if.sv
// Read port toward the convolution core's output RAM plus the valid/ready result
// stream toward the consumer; master is the drain stage.
interface conv_result_drain_if #(
   parameter int n = 8,
   parameter int m = 6
);
   logic         rd;
   logic [m-1:0] adr;
   logic [n-1:0] dataout;
   logic [n-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;

   modport master (
      output rd, adr, out_data, out_valid, out_last,
      input  dataout, out_ready
   );

   modport slave (
      input  rd, adr, out_data, out_valid, out_last,
      output dataout, out_ready
   );
endinterface

// File: rtl/conv_result_drain.sv
// Drains k results from the convolution core's output RAM through a 4-entry FIFO
// onto a valid/ready stream with a last marker, tracking the frame maximum.
module conv_result_drain #(
   parameter int n = 8,
   parameter int m = 6,
   parameter int k = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 done,
   conv_result_drain_if.master  bus,
   output logic                 busy,
   output logic                 finished,
   output logic [n-1:0]         max_val
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   localparam logic [m:0]   k_cnt    = (m+1)'(k);
   localparam logic [m-1:0] last_idx = m'(k-1);

   state_t       state;
   logic         rd_q;
   logic         rd_d;
   logic [m-1:0] adr_q;
   logic [m:0]   issue_cnt;
   logic [m-1:0] xfer_idx;

   logic [n-1:0] mem [4];
   logic [1:0]   wr_ptr;
   logic [1:0]   rd_ptr;
   logic [2:0]   fifo_count;
   logic [2:0]   count_next;
   logic [3:0]   occupancy;
   logic         wr_en;
   logic         pop;
   logic         out_valid;
   logic         out_last;

   // RAM data arrives the cycle after rd, so the delayed strobe is the capture enable.
   assign wr_en     = rd_d;
   assign out_valid = (fifo_count != 3'd0);
   assign out_last  = out_valid && (xfer_idx == last_idx);
   assign pop       = out_valid && bus.out_ready;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      count_next = fifo_count;
      case ({wr_en, pop})
         2'b10:   count_next = fifo_count + 3'd1;
         2'b01:   count_next = fifo_count - 3'd1;
         default: count_next = fifo_count;
      endcase
   end

   // Words held after this edge plus the read still outstanding; must stay below 4 to issue.
   assign occupancy = {1'b0, count_next} + {3'b000, rd_q};

   // NOTE: storage is not reset; out_data is masked while the FIFO is empty so stale words never show.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= bus.dataout;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         rd_q       <= 1'b0;
         rd_d       <= 1'b0;
         adr_q      <= '0;
         issue_cnt  <= '0;
         xfer_idx   <= '0;
         wr_ptr     <= 2'd0;
         rd_ptr     <= 2'd0;
         fifo_count <= 3'd0;
         busy       <= 1'b0;
         finished   <= 1'b0;
         max_val    <= '0;
      end else begin
         rd_d       <= rd_q;
         finished   <= 1'b0;
         fifo_count <= count_next;

         if (wr_en) begin
            wr_ptr <= wr_ptr + 2'd1;
            if (bus.dataout > max_val) max_val <= bus.dataout;
         end
         if (pop) begin
            rd_ptr   <= rd_ptr + 2'd1;
            xfer_idx <= xfer_idx + 1'b1;
         end

         case (state)
            IDLE: begin
               if (done) begin
                  state     <= READ;
                  busy      <= 1'b1;
                  rd_q      <= 1'b1;
                  adr_q     <= '0;
                  issue_cnt <= (m+1)'(1);
                  xfer_idx  <= '0;
                  max_val   <= '0;
               end
            end
            READ: begin
               if (issue_cnt == k_cnt) begin
                  rd_q  <= 1'b0;
                  state <= DRAIN;
               end else if (occupancy < 4'd4) begin
                  rd_q      <= 1'b1;
                  adr_q     <= issue_cnt[m-1:0];
                  issue_cnt <= issue_cnt + 1'b1;
               end else begin
                  rd_q <= 1'b0;
               end
            end
            DRAIN: begin
               if (pop && out_last) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  finished <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rd        = rd_q;
   assign bus.adr       = adr_q;
   assign bus.out_valid = out_valid;
   assign bus.out_last  = out_last;
   assign bus.out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_conv_result_drain.sv
// Scoreboard bench for conv_result_drain: frames push expected words, a negedge
// monitor pops and compares on every accepted transfer.
module tb_conv_result_drain;
   localparam int n = 8;
   localparam int m = 6;
   localparam int k = 9;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         done = 1'b0;
   logic         done1 = 1'b0;
   logic         busy, finished, busy1, finished1;
   logic [n-1:0] max_val, max_val1;

   conv_result_drain_if #(.n(n), .m(m)) bus  ();
   conv_result_drain_if #(.n(n), .m(m)) bus1 ();

   conv_result_drain #(.n(n), .m(m), .k(k)) dut (
      .clk(clk), .rst(rst), .done(done), .bus(bus.master),
      .busy(busy), .finished(finished), .max_val(max_val)
   );

   conv_result_drain #(.n(n), .m(m), .k(1)) dut1 (
      .clk(clk), .rst(rst), .done(done1), .bus(bus1.master),
      .busy(busy1), .finished(finished1), .max_val(max_val1)
   );

   always #5 clk = ~clk;

   logic [n-1:0] ram [64];
   initial begin
      bus.dataout  = '0;
      bus1.dataout = '0;
   end
   always @(posedge clk) if (bus.rd)  bus.dataout  <= ram[bus.adr];
   always @(posedge clk) if (bus1.rd) bus1.dataout <= ram[bus1.adr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [n-1:0] data;
      logic         last;
   } exp_t;
   exp_t exp_q[$];

   int rd_cnt = 0, xfer_cnt = 0, fin_cnt = 0, last_edge = 0;

   always @(negedge clk) begin
      if (bus.rd) begin
         check("adr_seq", bus.adr, rd_cnt);
         check("rd_only_busy", busy, 1);
         rd_cnt++;
      end
      if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got %0d, expected no transfer", bus.out_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_last", bus.out_last, e.last);
         end
         xfer_cnt++;
         if (bus.out_last) last_edge = cyc + 1;
      end
      if (finished) begin
         check("finished_timing", cyc, last_edge);
         fin_cnt++;
      end
   end

   task automatic tick(input int c = 1);
      repeat (c) @(posedge clk);
      #1;
   endtask

   task automatic start_frame(output int e0);
      rd_cnt = 0; xfer_cnt = 0; fin_cnt = 0;
      for (int i = 0; i < k; i++) begin
         exp_t e;
         e.data = ram[i];
         e.last = (i == k-1);
         exp_q.push_back(e);
      end
      done = 1'b1;
      tick();
      e0 = cyc;
      done = 1'b0;
   endtask

   task automatic wait_finish(input string name);
      int t = 0;
      while (fin_cnt == 0 && t < 200) begin
         tick();
         t++;
      end
      check({name, "_finished"}, fin_cnt, 1);
      tick(2);
      check({name, "_single_pulse"}, fin_cnt, 1);
      check({name, "_idle"}, busy, 0);
      check({name, "_queue_drained"}, exp_q.size(), 0);
   endtask

   task automatic set_ram_ramp();
      for (int i = 0; i < 64; i++) ram[i] = (i < k) ? n'(10 * (i + 1)) : '0;
   endtask

   initial begin
      int e0;
      int t;
      int rd1, words1, fin1;

      set_ram_ramp();
      bus.out_ready  = 1'b1;
      bus1.out_ready = 1'b1;

      // Reset then idle
      tick(2);
      rst = 1'b1;
      tick();
      check("rst_busy", busy, 0);
      check("rst_finished", finished, 0);
      check("rst_max", max_val, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_data", bus.out_data, 0);
      check("rst_last", bus.out_last, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("idle_rd", bus.rd, 0);
      end

      // Nominal drain
      start_frame(e0);
      @(negedge clk);
      check("lat_rd", bus.rd, 1);
      check("lat_busy", busy, 1);
      check("lat_valid_e0", bus.out_valid, 0);
      tick();
      check("lat_valid_e1", bus.out_valid, 0);
      tick();
      check("lat_valid_e2", bus.out_valid, 1);
      check("lat_data_e2", bus.out_data, 10);
      wait_finish("nominal");
      check("nominal_latency", last_edge - e0, k + 2);
      check("nominal_max", max_val, 90);
      check("nominal_reads", rd_cnt, k);
      check("nominal_words", xfer_cnt, k);

      // Backpressure
      bus.out_ready = 1'b0;
      start_frame(e0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            check("bp_valid", bus.out_valid, 1);
            check("bp_data_hold", bus.out_data, 10);
            check("bp_last_hold", bus.out_last, 0);
         end
      end
      tick();
      check("bp_reads", rd_cnt, 4);
      check("bp_rd_low", bus.rd, 0);
      bus.out_ready = 1'b1;
      wait_finish("bp");
      check("bp_words", xfer_cnt, k);

      // Max tracking
      ram[0] = 7; ram[1] = 255; ram[2] = 3; ram[3] = 0; ram[4] = 128;
      ram[5] = 1; ram[6] = 2;   ram[7] = 4; ram[8] = 8;
      check("max_held_idle", max_val, 90);
      start_frame(e0);
      check("max_cleared", max_val, 0);
      tick(2);
      check("max_capture1", max_val, 7);
      tick();
      check("max_capture2", max_val, 255);
      wait_finish("max");
      tick(5);
      check("max_hold", max_val, 255);

      // Extra done while reading
      set_ram_ramp();
      start_frame(e0);
      tick(2);
      done = 1'b1;
      tick();
      done = 1'b0;
      wait_finish("extra_done");
      tick(5);
      check("extra_done_words", xfer_cnt, k);
      check("extra_done_reads", rd_cnt, k);
      check("extra_done_no_restart", busy, 0);

      // Reset mid-frame
      start_frame(e0);
      t = 0;
      while (xfer_cnt < 4 && t < 100) begin
         tick();
         t++;
      end
      check("midrst_reached4", xfer_cnt, 4);
      #2 rst = 1'b0;
      #1;
      check("midrst_rd", bus.rd, 0);
      check("midrst_valid", bus.out_valid, 0);
      check("midrst_data", bus.out_data, 0);
      check("midrst_last", bus.out_last, 0);
      check("midrst_busy", busy, 0);
      check("midrst_max", max_val, 0);
      exp_q.delete();
      tick();
      rst = 1'b1;
      tick(2);
      check("midrst_idle_rd", bus.rd, 0);
      start_frame(e0);
      wait_finish("restart");
      check("restart_words", xfer_cnt, k);
      check("restart_reads", rd_cnt, k);

      // k = 1 instance
      rd1 = 0; words1 = 0; fin1 = 0;
      done1 = 1'b1;
      tick();
      done1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus1.rd) begin
            check("k1_adr", bus1.adr, 0);
            rd1++;
         end
         if (bus1.out_valid) begin
            check("k1_data", bus1.out_data, ram[0]);
            check("k1_last", bus1.out_last, 1);
            words1++;
         end
         if (finished1) fin1++;
      end
      check("k1_reads", rd1, 1);
      check("k1_words", words1, 1);
      check("k1_finished", fin1, 1);
      check("k1_max", max_val1, ram[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
